// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS-I integer subset core: FETCH/DECODE/EXEC/MEM/WB FSM with an
// internal register file, internal data memory, sticky illegal-opcode trap and debug read.
module mips_multicycle_cpu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DMEM_WORDS = 256,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  instr_req,
  output logic [DATA_WIDTH-1:0] instr_addr,
  input  logic                  instr_valid,
  input  logic [31:0]           instr_data,
  output logic                  retire,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  trap,
  input  logic [4:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int unsigned RegAw = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned DmemAw = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [RegAw-1:0] LinkReg = RegAw'(31);
  localparam logic [DATA_WIDTH-1:0] JMask = DATA_WIDTH'({28{1'b1}});

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           ir_q, ir_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d, mdr_q, mdr_d;
  logic                  trap_q, trap_d, instr_req_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] dmem_q [DMEM_WORDS];

  logic                  rf_we;
  logic [RegAw-1:0]      rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  dmem_we;

  logic [5:0]            opcode, funct;
  logic [RegAw-1:0]      rs_idx, rt_idx, rd_idx;
  logic [DATA_WIDTH-1:0] imm_sext, pc_plus4, jump_target, alu_r;
  logic [DmemAw-1:0]     mem_idx;
  logic                  legal;
  logic                  unused_bits;

  assign opcode      = ir_q[31:26];
  assign funct       = ir_q[5:0];
  assign rs_idx      = ir_q[21 +: RegAw];
  assign rt_idx      = ir_q[16 +: RegAw];
  assign rd_idx      = ir_q[11 +: RegAw];
  assign imm_sext    = DATA_WIDTH'($signed(ir_q[15:0]));
  assign pc_plus4    = pc_q + DATA_WIDTH'(4);
  assign jump_target = (pc_plus4 & ~JMask) | DATA_WIDTH'({ir_q[25:0], 2'b00});
  assign mem_idx     = alu_q[DmemAw+1:2];
  assign unused_bits = ^ir_q[10:6];

  assign instr_req  = instr_req_q;
  assign instr_addr = pc_q;
  assign pc         = pc_q;
  assign trap       = trap_q;
  assign dbg_data   = regs_q[dbg_addr[RegAw-1:0]];

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OpRtype: legal = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                       (funct == FnOr) || (funct == FnSlt);
      OpJ, OpJal, OpBeq, OpAddi, OpLw, OpSw: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_r = a_q + b_q;
    case (funct)
      FnSub:   alu_r = a_q - b_q;
      FnAnd:   alu_r = a_q & b_q;
      FnOr:    alu_r = a_q | b_q;
      FnSlt:   alu_r = DATA_WIDTH'($signed(a_q) < $signed(b_q));
      default: alu_r = a_q + b_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    trap_d   = trap_q;
    rf_we    = 1'b0;
    rf_waddr = rd_idx;
    rf_wdata = alu_q;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (instr_req_q && instr_valid) begin
          ir_d    = instr_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d   = regs_q[rs_idx];
        b_d   = regs_q[rt_idx];
        imm_d = imm_sext;
        if (!legal) begin
          trap_d  = 1'b1;
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (opcode)
          OpRtype: begin
            alu_d   = alu_r;
            state_d = StWb;
          end
          OpBeq: begin
            pc_d    = (a_q == b_q) ? pc_plus4 + (imm_q << 2) : pc_plus4;
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpJ: begin
            pc_d    = jump_target;
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpJal: begin
            alu_d   = pc_plus4;
            state_d = StWb;
          end
          OpLw, OpSw: begin
            alu_d   = a_q + imm_q;
            state_d = StMem;
          end
          default: begin
            alu_d   = a_q + imm_q;
            state_d = StWb;
          end
        endcase
      end
      StMem: begin
        if (opcode == OpSw) begin
          dmem_we = 1'b1;
          pc_d    = pc_plus4;
          retire  = 1'b1;
          state_d = StFetch;
        end else begin
          mdr_d   = dmem_q[mem_idx];
          state_d = StWb;
        end
      end
      StWb: begin
        rf_we    = 1'b1;
        rf_waddr = (opcode == OpRtype) ? rd_idx : (opcode == OpJal) ? LinkReg : rt_idx;
        rf_wdata = (opcode == OpLw) ? mdr_q : alu_q;
        pc_d     = (opcode == OpJal) ? jump_target : pc_plus4;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      alu_q       <= '0;
      mdr_q       <= '0;
      trap_q      <= 1'b0;
      instr_req_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      alu_q       <= alu_d;
      mdr_q       <= mdr_d;
      trap_q      <= trap_d;
      // Request is registered so it rises on the edge that enters FETCH.
      instr_req_q <= (state_d == StFetch);
      if (rf_we && (rf_waddr != '0)) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Data memory keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (dmem_we) dmem_q[mem_idx] <= b_q;
  end

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Self-checking bench for mips_multicycle_cpu: retire latencies go through a scoreboard
// queue; architectural state is checked through pc, trap and the debug read port.
module tb_mips_multicycle_cpu;

  logic        clock;
  logic        reset_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic        retire;
  logic [31:0] pc;
  logic        trap;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;
  int sb[$];
  int cyc = 0;
  bit in_flight = 0;

  mips_multicycle_cpu #(
    .DATA_WIDTH(32),
    .NUM_REGS(32),
    .DMEM_WORDS(256),
    .RESET_PC(32'h0)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .instr_req(instr_req),
    .instr_addr(instr_addr),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .retire(retire),
    .pc(pc),
    .trap(trap),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Retire monitor: cycle 1 is the acceptance cycle.
  always @(negedge clock) begin
    if (!reset_n) begin
      in_flight = 0;
    end else begin
      if (in_flight) cyc++;
      if (retire) begin
        if (sb.size() == 0) check_eq("spurious_retire", 32'(retire), 32'h0);
        else check_eq("latency", 32'(cyc), 32'(sb.pop_front()));
        in_flight = 0;
      end
      if (instr_req && instr_valid) begin
        in_flight = 1;
        cyc = 1;
      end
    end
  end

  task automatic wait_req();
    int n;
    n = 0;
    while (!instr_req && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_eq("req_seen", 32'(instr_req), 32'h1);
  endtask

  task automatic issue(input logic [31:0] instr, input int pre, input int lat,
                       input logic [31:0] exp_pc);
    logic [31:0] pc_hold;
    int n;
    wait_req();
    pc_hold = pc;
    check_eq("instr_addr", instr_addr, pc_hold);
    repeat (pre) begin
      @(posedge clock);
      #1;
      check_eq("wait_pc", pc, pc_hold);
      check_eq("wait_retire", 32'(retire), 32'h0);
    end
    sb.push_back(lat);
    instr_valid = 1'b1;
    instr_data  = instr;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr_data  = $urandom;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_eq("retire_seen", 32'(sb.size()), 32'h0);
    sb.delete();
    check_eq("pc_after", pc, exp_pc);
  endtask

  task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check_eq(tag, dbg_data, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_req", 32'(instr_req), 32'h0);
    check_eq("rst_trap", 32'(trap), 32'h0);
    check_eq("rst_retire", 32'(retire), 32'h0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_eq("req_after_rst", 32'(instr_req), 32'h1);
  endtask

  task automatic illegal(input logic [31:0] instr, input string tag);
    logic [31:0] pc_hold;
    wait_req();
    pc_hold = pc;
    instr_valid = 1'b1;
    instr_data  = instr;
    @(posedge clock);
    #1;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    check_eq({tag, "_trap"}, 32'(trap), 32'h1);
    check_eq({tag, "_req"}, 32'(instr_req), 32'h0);
    // Valid without a request must be ignored while halted.
    repeat (6) begin
      @(posedge clock);
      #1;
    end
    instr_valid = 1'b0;
    check_eq({tag, "_pc"}, pc, pc_hold);
    check_eq({tag, "_trap_held"}, 32'(trap), 32'h1);
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 32'h0;
    dbg_addr    = 5'd0;
    #12;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_req", 32'(instr_req), 32'h0);
    check_eq("rst_trap", 32'(trap), 32'h0);
    check_reg("rst_r1", 5'd1, 32'h0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_eq("req_first_edge", 32'(instr_req), 32'h1);

    issue(32'h20010005, 1, 4, 32'h04);   // addi r1,r0,5
    check_reg("r1", 5'd1, 32'h5);
    issue(32'h2002FFF9, 0, 4, 32'h08);   // addi r2,r0,-7
    check_reg("r2", 5'd2, 32'hFFFFFFF9);
    issue(32'h00221820, 7, 4, 32'h0C);   // add r3,r1,r2
    check_reg("add_r3", 5'd3, 32'hFFFFFFFE);
    issue(32'h00613022, 0, 4, 32'h10);   // sub r6,r3,r1
    check_reg("sub_r6", 5'd6, 32'hFFFFFFF9);
    issue(32'h0061202A, 2, 4, 32'h14);   // slt r4,r3,r1
    check_reg("slt_r4", 5'd4, 32'h1);
    issue(32'h00223824, 0, 4, 32'h18);   // and r7,r1,r2
    check_reg("and_r7", 5'd7, 32'h1);
    issue(32'h00224025, 0, 4, 32'h1C);   // or r8,r1,r2
    check_reg("or_r8", 5'd8, 32'hFFFFFFFD);
    issue(32'hAC010008, 0, 4, 32'h20);   // sw r1,8(r0)
    issue(32'h8C050008, 0, 5, 32'h24);   // lw r5,8(r0)
    check_reg("lw_r5", 5'd5, 32'h5);
    issue(32'h8C090408, 0, 5, 32'h28);   // lw r9,0x408(r0): aliases word 2
    check_reg("lw_alias_r9", 5'd9, 32'h5);
    issue(32'h1021FFFF, 0, 3, 32'h28);   // beq r1,r1,-1
    issue(32'h10200003, 0, 3, 32'h2C);   // beq r1,r0,+3 not taken
    issue(32'h10000003, 0, 3, 32'h3C);   // beq r0,r0,+3 taken
    issue(32'h08000010, 0, 3, 32'h40);   // j 0x10
    issue(32'h0C000040, 0, 4, 32'h100);  // jal 0x40
    check_reg("jal_r31", 5'd31, 32'h44);
    issue(32'h20000007, 0, 4, 32'h104);  // addi r0,r0,7
    check_reg("r0_zero", 5'd0, 32'h0);

    // Reset during EXEC of addi r2,r0,9.
    wait_req();
    instr_valid = 1'b1;
    instr_data  = 32'h20020009;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    @(posedge clock);
    #1;
    do_reset();
    check_reg("mid_rst_r2", 5'd2, 32'h0);
    check_reg("mid_rst_r1", 5'd1, 32'h0);
    issue(32'h8C050008, 0, 5, 32'h04);   // lw r5,8(r0): store survives reset
    check_reg("mem_persist_r5", 5'd5, 32'h5);

    illegal(32'hFC000000, "ill_op");
    illegal(32'h00000001, "ill_fn");
    issue(32'h2001000B, 0, 4, 32'h04);   // addi r1,r0,11 after trap recovery
    check_reg("post_trap_r1", 5'd1, 32'hB);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
